// File: rtl/instr_stream_loader.sv
// Boot-time producer for the CPU's flat instruction_stream bus: buffers a streamed image and sequences cpu_rst.
// Optional feature macro: LOADER_CHECKSUM_EN adds a running XOR checksum output of the accepted words.
module instr_stream_loader #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_start,
    input  logic                      in_valid,
    input  logic [WORD_W-1:0]         in_data,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [DEPTH*WORD_W-1:0]   instruction_stream,
    output logic                      cpu_rst,
    output logic                      load_done,
    output logic [ADDR_W:0]           word_count,
`ifdef LOADER_CHECKSUM_EN
    output logic [WORD_W-1:0]         checksum,
`endif
    output logic                      overflow_err
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                         state_q;
    state_t                         state_d;
    logic [HOLD_W-1:0]              hold_cnt;
    logic [DEPTH-1:0][WORD_W-1:0]   buf_q;
    logic                           accept_c;
    logic                           start_c;
    logic                           last_slot_c;
    logic                           hold_term_c;

    assign instruction_stream = buf_q;

    assign accept_c    = in_valid && in_ready;
    assign start_c     = load_start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_slot_c = (word_count == CNT_W'(DEPTH - 1));
    assign hold_term_c = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

    // Next-state logic; LOAD exits on in_last or when the final buffer slot is filled
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_c) state_d = S_LOAD;
            S_LOAD:  if (accept_c && (in_last || last_slot_c)) state_d = S_HOLD;
            S_HOLD:  if (hold_term_c) state_d = S_DONE;
            S_DONE:  if (start_c) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // State register plus outputs registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            in_ready  <= 1'b0;
            cpu_rst   <= 1'b1;
            load_done <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == S_LOAD);
            cpu_rst   <= (state_d != S_DONE);
            load_done <= (state_d == S_DONE);
            hold_cnt  <= (state_q == S_HOLD) ? hold_cnt + HOLD_W'(1) : '0;
        end
    end

    // Image buffer, word counter and overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q        <= '0;
            word_count   <= '0;
            overflow_err <= 1'b0;
        end else if (start_c) begin
            buf_q        <= '0;
            word_count   <= '0;
            overflow_err <= 1'b0;
        end else if (accept_c) begin
            buf_q[word_count[ADDR_W-1:0]] <= in_data;
            if (word_count != CNT_W'(DEPTH)) begin
                word_count <= word_count + CNT_W'(1);
            end
            if (last_slot_c && !in_last) begin
                overflow_err <= 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of every word accepted in the current load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum <= '0;
        end else if (start_c) begin
            checksum <= '0;
        end else if (accept_c) begin
            checksum <= checksum ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_instr_stream_loader.sv
// Directed self-checking bench for instr_stream_loader (default parameters).
// Honours LOADER_CHECKSUM_EN when defined.
module tb_instr_stream_loader;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned HOLD   = 4;

    logic                     clk;
    logic                     rst;
    logic                     load_start;
    logic                     in_valid;
    logic [WORD_W-1:0]        in_data;
    logic                     in_last;
    logic                     in_ready;
    logic [DEPTH*WORD_W-1:0]  instruction_stream;
    logic                     cpu_rst;
    logic                     load_done;
    logic [ADDR_W:0]          word_count;
    logic                     overflow_err;
`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0]        checksum;
`endif

    int n_checks;
    int n_fails;

    instr_stream_loader #(
        .DEPTH(DEPTH), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_start(load_start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_last(in_last),
        .in_ready(in_ready),
        .instruction_stream(instruction_stream),
        .cpu_rst(cpu_rst),
        .load_done(load_done),
        .word_count(word_count),
`ifdef LOADER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WORD_W-1:0] word_at(input int i);
        return instruction_stream[i*WORD_W +: WORD_W];
    endfunction

    // Present one word and wait (bounded) until it is taken
    task automatic send(input logic [WORD_W-1:0] d, input logic last);
        int budget;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        budget   = 0;
        while (!in_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        while (!load_done && budget < 50) begin
            tick();
            budget++;
        end
        check("done_timeout", 64'(load_done), 64'd1);
    endtask

    logic all_zero;

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        rst        = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        #12;
        check("rst_cpu_rst",   64'(cpu_rst), 64'd1);
        check("rst_in_ready",  64'(in_ready), 64'd0);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_count",     64'(word_count), 64'd0);
        rst = 1'b1;
        tick();

        // Basic load; load_start together with in_valid in IDLE takes no word
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 32'h2008_0005;
        tick();
        load_start = 1'b0;
        check("idle_no_accept", 64'(word_count), 64'd0);
        check("load_ready",     64'(in_ready), 64'd1);
        send(32'h2008_0005, 1'b0);
        send(32'h2009_0003, 1'b0);
        send(32'h0109_5020, 1'b1);
        check("basic_w0",    64'(word_at(0)), 64'h2008_0005);
        check("basic_w1",    64'(word_at(1)), 64'h2009_0003);
        check("basic_w2",    64'(word_at(2)), 64'h0109_5020);
        check("basic_count", 64'(word_count), 64'd3);
        check("hold_ready",  64'(in_ready), 64'd0);
        for (int i = 1; i < int'(HOLD); i++) tick();
        check("hold_cpu_rst_hi",  64'(cpu_rst), 64'd1);
        check("hold_not_done",    64'(load_done), 64'd0);
        tick();
        check("release_cpu_rst",  64'(cpu_rst), 64'd0);
        check("release_done",     64'(load_done), 64'd1);

        // in_valid in DONE is ignored
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        tick();
        tick();
        in_valid = 1'b0;
        check("done_no_accept", 64'(word_count), 64'd3);
        check("done_stays",     64'(load_done), 64'd1);

        // Gapped stream: valid 1,0,1,1 with last on third valid word
        start_load();
        in_valid = 1'b1; in_data = 32'h1111_1111; in_last = 1'b0; tick();
        in_valid = 1'b0; in_data = 32'h9999_9999; tick();
        check("gap_count", 64'(word_count), 64'd1);
        in_valid = 1'b1; in_data = 32'h2222_2222; tick();
        in_data  = 32'h3333_3333; in_last = 1'b1; tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("gap_w0",    64'(word_at(0)), 64'h1111_1111);
        check("gap_w1",    64'(word_at(1)), 64'h2222_2222);
        check("gap_w2",    64'(word_at(2)), 64'h3333_3333);
        check("gap_w3",    64'(word_at(3)), 64'h0);
        check("gap_count3", 64'(word_count), 64'd3);
        wait_done();

        // Overflow: DEPTH words without in_last, valid held high afterwards
        start_load();
        in_valid = 1'b1;
        in_last  = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            in_data = WORD_W'(i + 1);
            tick();
            if (i == int'(DEPTH) - 2) check("ovf_not_yet", 64'(overflow_err), 64'd0);
        end
        in_data = 32'hFFFF_FFFF;
        check("ovf_flag",   64'(overflow_err), 64'd1);
        check("ovf_count",  64'(word_count), 64'd1024);
        check("ovf_ready",  64'(in_ready), 64'd0);
        tick();
        check("ovf_no_1025", 64'(word_count), 64'd1024);
        check("ovf_w0",     64'(word_at(0)), 64'd1);
        check("ovf_wlast",  64'(word_at(int'(DEPTH) - 1)), 64'd1024);
        wait_done();
        in_valid = 1'b0;

        // in_last on word DEPTH is a normal completion
        start_load();
        check("clr_ovf", 64'(overflow_err), 64'd0);
        in_valid = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            in_data = WORD_W'(32'h5000_0000 + i);
            in_last = (i == int'(DEPTH) - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("full_no_ovf", 64'(overflow_err), 64'd0);
        check("full_count",  64'(word_count), 64'd1024);
        wait_done();

        // Reload from DONE with one word
        start_load();
        check("reload_cpu_rst", 64'(cpu_rst), 64'd1);
        check("reload_done_lo", 64'(load_done), 64'd0);
        send(32'hAAAA_AAAA, 1'b1);
        check("reload_w0", 64'(word_at(0)), 64'hAAAA_AAAA);
        all_zero = 1'b1;
        for (int i = 1; i < int'(DEPTH); i++) if (word_at(i) != '0) all_zero = 1'b0;
        check("reload_rest_zero", 64'(all_zero), 64'd1);
        wait_done();

`ifdef LOADER_CHECKSUM_EN
        check("cks_prev", 64'(checksum), 64'hAAAA_AAAA);
        start_load();
        check("cks_clear", 64'(checksum), 64'h0);
        send(32'h0F0F_0F0F, 1'b0);
        send(32'h00FF_00FF, 1'b1);
        check("cks_value", 64'(checksum), 64'h0FF0_0FF0);
        wait_done();
`endif

        // Asynchronous reset mid-load after 3 words
        start_load();
        send(32'h1234_5678, 1'b0);
        send(32'h2345_6789, 1'b0);
        send(32'h3456_789A, 1'b0);
        check("pre_rst_count", 64'(word_count), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        check("arst_cpu_rst",  64'(cpu_rst), 64'd1);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        check("arst_count",    64'(word_count), 64'd0);
        check("arst_stream",   64'(instruction_stream == '0), 64'd1);
        #5;
        rst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
